// File: rtl/delay_sweep_ctrl.sv
// delay_sweep_ctrl: steps the DELAY_OUT base delay (delay_1) from a start value to a
// stop value, dwelling a programmed number of tstart periods per step. Each new
// value is loaded on a period boundary through the init strobe. While dwelling,
// TDC results can optionally be forwarded for closed-loop tracking.
module delay_sweep_ctrl #(
  parameter int unsigned DW    = 15,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             abort,
  input  logic             track_en,
  input  logic [DW-1:0]    delay_start,
  input  logic [DW-1:0]    delay_stop,
  input  logic [DW-1:0]    delay_step,
  input  logic [CNT_W-1:0] dwell_periods,
  input  logic             tstart,
  input  logic             tdc_valid,
  input  logic [DW-1:0]    tdc_in,
  output logic [DW-1:0]    delay_1,
  output logic             init,
  output logic             tdc_data_flag,
  output logic [DW-1:0]    tdc_data,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] step_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_LOAD  = 3'd2,
    S_DWELL = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic             tstart_q;
  logic [DW-1:0]    stop_q, stop_d;
  logic [DW-1:0]    step_q, step_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [DW-1:0]    cur_q, cur_d;
  logic [CNT_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [CNT_W-1:0] step_idx_q, step_idx_d;
  logic [DW-1:0]    delay_1_q, delay_1_d;
  logic             init_q, init_d;
  logic             flag_q, flag_d;
  logic [DW-1:0]    tdc_data_q, tdc_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic             pb;
  logic [DW:0]      nxt;
  logic             sweep_end;

  // Period boundary is the rising edge of tstart; next value carries one extra bit
  // so an overflow past the top of the delay range ends the sweep instead of wrapping.
  assign pb        = tstart & ~tstart_q;
  assign nxt       = {1'b0, cur_q} + {1'b0, step_q};
  assign sweep_end = (step_q == '0) | nxt[DW] | (nxt[DW-1:0] > stop_q);

  // Next-state, shadow config and registered-output computation
  always_comb begin
    state_d     = state_q;
    stop_d      = stop_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    cur_d       = cur_q;
    dwell_cnt_d = dwell_cnt_q;
    step_idx_d  = step_idx_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ARM;
          stop_d     = delay_stop;
          step_d     = delay_step;
          dwell_d    = dwell_periods;
          cur_d      = delay_start;
          step_idx_d = '0;
        end
      end
      S_ARM: begin
        if (pb) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d     = S_DWELL;
        dwell_cnt_d = (dwell_q == '0) ? CNT_W'(1) : dwell_q;
      end
      S_DWELL: begin
        if (pb) begin
          if (dwell_cnt_q == CNT_W'(1)) state_d = S_NEXT;
          else dwell_cnt_d = dwell_cnt_q - CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (sweep_end) begin
          state_d = S_DONE;
        end else if (pb) begin
          state_d    = S_LOAD;
          cur_d      = nxt[DW-1:0];
          step_idx_d = step_idx_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides any in-flight transition; current step is preserved
    if (abort && (state_q != S_IDLE)) begin
      state_d    = S_IDLE;
      cur_d      = cur_q;
      step_idx_d = step_idx_q;
      aborted_d  = 1'b1;
    end

    init_d     = (state_d == S_LOAD);
    delay_1_d  = (state_d == S_LOAD) ? cur_d : delay_1_q;
    done_d     = (state_d == S_DONE);
    busy_d     = (state_d != S_IDLE);
    flag_d     = track_en & tdc_valid & (state_q == S_DWELL) & ~init_d;
    tdc_data_d = tdc_in;
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      tstart_q    <= 1'b0;
      stop_q      <= '0;
      step_q      <= '0;
      dwell_q     <= '0;
      cur_q       <= '0;
      dwell_cnt_q <= '0;
      step_idx_q  <= '0;
      delay_1_q   <= '0;
      init_q      <= 1'b0;
      flag_q      <= 1'b0;
      tdc_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tstart_q    <= tstart;
      stop_q      <= stop_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      cur_q       <= cur_d;
      dwell_cnt_q <= dwell_cnt_d;
      step_idx_q  <= step_idx_d;
      delay_1_q   <= delay_1_d;
      init_q      <= init_d;
      flag_q      <= flag_d;
      tdc_data_q  <= tdc_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign delay_1       = delay_1_q;
  assign init          = init_q;
  assign tdc_data_flag = flag_q;
  assign tdc_data      = tdc_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign step_idx      = step_idx_q;

endmodule
